// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM and its clear engine.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic bit read_latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: zero-fills every word once after reset and again on request,
// owning the array write port while busy.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The counter parks on the last address instead of wrapping.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_we   = busy;
        clr_addr = clr_cnt_q;
    end

endmodule

// File: rtl/sync_dp_ram.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read latency,
// selectable same-address read/write policy and a built-in zero-fill engine.
module sync_dp_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!read_latency_legal(READ_LATENCY) || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("sync_dp_ram: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_wr, user_rd;
    logic [DATA_WIDTH-1:0] wr_merged, rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    ram_clear_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign user_wr = we & ~busy;
    assign user_rd = re & ~busy;

    // Word the array will hold after this cycle's write; feeds the write-first bypass.
    always_comb begin
        wr_merged = mem_q[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) wr_merged[b*8 +: 8] = din[b*8 +: 8];
        end
    end

    always_comb begin
        rd_word = mem_q[raddr];
        if (RDW_MODE == RDW_WRITE_FIRST && user_wr && waddr == raddr) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (user_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) mem_q[waddr][b*8 +: 8] <= din[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= user_rd;
            if (user_rd) rd_data_q <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) out_data_q <= rd_data_q;
            end
        end

        assign dout       = out_data_q;
        assign dout_valid = out_valid_q;
    end else begin : g_lat1
        assign dout       = rd_data_q;
        assign dout_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_dp_ram.sv
// Scoreboard bench driving two RAM instances in lockstep: latency 1 read-first
// and latency 2 write-first, each with its own expected-read queue.
module tb_sync_dp_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LAT_A = 1;
    localparam int RDW_A = 0;
    localparam int LAT_B = 2;
    localparam int RDW_B = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        int            accEdge;
    } readExp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clrReq = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    wbe = '0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] din = '0;
    logic          re = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic          busyA, busyB, validA, validB;
    logic [DW-1:0] doutA, doutB;

    int            assertCount = 0;
    int            failCount = 0;
    int            cyc = 0;
    int            busyLeft = 0;
    logic [DW-1:0] modelMem [DEPTH];
    readExp_t      queueA[$];
    readExp_t      queueB[$];
    readExp_t      popA, popB;
    logic [DW-1:0] lastA = '0;
    logic [DW-1:0] lastB = '0;

    sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT_A), .RDW_MODE(RDW_A)) dutA (
        .clk(clk), .rst(rst), .clr_req(clrReq), .busy(busyA), .we(we), .wbe(wbe),
        .waddr(waddr), .din(din), .re(re), .raddr(raddr), .dout(doutA), .dout_valid(validA)
    );

    sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT_B), .RDW_MODE(RDW_B)) dutB (
        .clk(clk), .rst(rst), .clr_req(clrReq), .busy(busyB), .we(we), .wbe(wbe),
        .waddr(waddr), .din(din), .re(re), .raddr(raddr), .dout(doutB), .dout_valid(validB)
    );

    // Free-running clock and an edge counter used to time-stamp reads.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point; every check in the bench is routed through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drives one cycle of stimulus from a negedge, updates the reference model
    // and pushes expected read results for both instances.
    task automatic applyStimulus(input logic iWe, input logic [1:0] iWbe, input logic [AW-1:0] iWaddr,
                                 input logic [DW-1:0] iDin, input logic iRe, input logic [AW-1:0] iRaddr,
                                 input logic iClr);
        logic [DW-1:0] oldWord, newWord;
        readExp_t      e;
        checkOutput("busyA", {31'b0, busyA}, {31'b0, busyLeft != 0});
        checkOutput("busyB", {31'b0, busyB}, {31'b0, busyLeft != 0});
        we = iWe; wbe = iWbe; waddr = iWaddr; din = iDin;
        re = iRe; raddr = iRaddr; clrReq = iClr;
        if (busyLeft == 0) begin
            oldWord = modelMem[iRaddr];
            newWord = modelMem[iWaddr];
            for (int b = 0; b < 2; b++) begin
                if (iWbe[b]) newWord[b*8 +: 8] = iDin[b*8 +: 8];
            end
            if (iRe) begin
                e.accEdge = cyc;
                e.data = (RDW_A == 1 && iWe && iWaddr == iRaddr) ? newWord : oldWord;
                queueA.push_back(e);
                e.data = (RDW_B == 1 && iWe && iWaddr == iRaddr) ? newWord : oldWord;
                queueB.push_back(e);
            end
            if (iWe) modelMem[iWaddr] = newWord;
        end
        if (busyLeft > 0) begin
            busyLeft--;
        end else if (iClr) begin
            busyLeft = DEPTH;
            foreach (modelMem[i]) modelMem[i] = '0;
        end
        @(negedge clk);
        we = 1'b0; wbe = '0; re = 1'b0; clrReq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        applyStimulus(1'b1, be, a, d, 1'b0, '0, 1'b0);
    endtask

    task automatic readWord(input logic [AW-1:0] a);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, a, 1'b0);
    endtask

    // Asserts reset off the clock edge, checks outputs respond asynchronously,
    // and releases on a negedge so the next call sees a full busy window.
    task automatic doReset();
        #2;
        rst = 1'b1;
        queueA.delete();
        queueB.delete();
        lastA = '0;
        lastB = '0;
        busyLeft = DEPTH;
        foreach (modelMem[i]) modelMem[i] = '0;
        #1;
        checkOutput("rst doutA", {16'b0, doutA}, 32'h0);
        checkOutput("rst validA", {31'b0, validA}, 32'h0);
        checkOutput("rst busyA", {31'b0, busyA}, 32'h1);
        checkOutput("rst doutB", {16'b0, doutB}, 32'h0);
        checkOutput("rst validB", {31'b0, validB}, 32'h0);
        checkOutput("rst busyB", {31'b0, busyB}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Output monitors: pop on each valid pulse, check data and arrival cycle,
    // and check dout holds its last value when no pulse is present.
    always @(negedge clk) begin
        if (!rst) begin
            if (validA) begin
                if (queueA.size() == 0) begin
                    checkOutput("A unexpected valid", 32'h1, 32'h0);
                end else begin
                    popA = queueA.pop_front();
                    checkOutput("A dout", {16'b0, doutA}, {16'b0, popA.data});
                    checkOutput("A latency", cyc, popA.accEdge + LAT_A);
                    lastA = popA.data;
                end
            end else begin
                checkOutput("A dout hold", {16'b0, doutA}, {16'b0, lastA});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (validB) begin
                if (queueB.size() == 0) begin
                    checkOutput("B unexpected valid", 32'h1, 32'h0);
                end else begin
                    popB = queueB.pop_front();
                    checkOutput("B dout", {16'b0, doutB}, {16'b0, popB.data});
                    checkOutput("B latency", cyc, popB.accEdge + LAT_B);
                    lastB = popB.data;
                end
            end else begin
                checkOutput("B dout hold", {16'b0, doutB}, {16'b0, lastB});
            end
        end
    end

    initial begin
        // Power-up clear, then a read of a freshly zeroed word.
        doReset();
        idle(DEPTH + 1);
        readWord(4'd1);
        idle(3);

        // Byte enables, including an all-zero enable that must not write.
        writeWord(4'd2, 16'hAABB, 2'b11);
        writeWord(4'd2, 16'h11CC, 2'b01);
        writeWord(4'd2, 16'h9999, 2'b00);
        readWord(4'd2);
        idle(3);

        // Same-address collision, then a plain read of the new word.
        writeWord(4'd4, 16'h1234, 2'b11);
        applyStimulus(1'b1, 2'b11, 4'd4, 16'h5678, 1'b1, 4'd4, 1'b0);
        readWord(4'd4);
        idle(3);

        // Back-to-back reads plus a write/read pair on different addresses.
        readWord(4'd2);
        readWord(4'd4);
        applyStimulus(1'b1, 2'b10, 4'd7, 16'hC3A5, 1'b1, 4'd2, 1'b0);
        readWord(4'd7);
        idle(4);

        // Requested clear: accesses while busy are dropped, then all words are zero.
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
        writeWord(4'd3, 16'hFFFF, 2'b11);
        readWord(4'd4);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
        idle(DEPTH - 2);
        for (int a = 0; a < DEPTH; a++) readWord(a[AW-1:0]);
        idle(4);

        // Reset with a read still in the pipeline of the two-stage instance.
        writeWord(4'd5, 16'hBEEF, 2'b11);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 4'd5, 1'b1);
        doReset();
        idle(DEPTH + 1);

        // Reset in the middle of a requested clear.
        writeWord(4'd5, 16'h0F0F, 2'b11);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
        idle(5);
        doReset();
        idle(DEPTH + 1);
        readWord(4'd5);
        idle(4);

        checkOutput("A queue drained", queueA.size(), 32'h0);
        checkOutput("B queue drained", queueB.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sync_dp_ram.md
# sync_dp_ram

Parametrised simple-dual-port synchronous RAM with one write port and one read port, per-byte write enables, and a configurable read latency of 1 or 2. A selectable read-during-write policy fixes the result when both ports hit the same address. A built-in clear engine zero-fills the array after reset and on request. It replaces the single-port `synchronous_ram` as the general on-chip storage block, used by buffers and register files that need concurrent read and write.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write policy; 0 = read-first (returns old data), 1 = write-first (returns new data).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  request a full zero-fill; sampled only in IDLE.
- busy  out  1  high while the clear engine owns the array.
- we  in  1  write enable.
- wbe  in  DATA_WIDTH/8  byte enables; bit i covers din[8i+7:8i].
- waddr  in  ADDR_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- re  in  1  read enable.
- raddr  in  ADDR_WIDTH  read address.
- dout  out  DATA_WIDTH  read data; holds its value between reads.
- dout_valid  out  1  one-cycle pulse per accepted read.

## Operation
- The FSM has two states, CLEAR and IDLE. Reset forces CLEAR with the clear counter at 0.
- **CLEAR:** writes 0 to address clr_cnt each cycle, then increments clr_cnt. At clr_cnt == DEPTH-1 it writes that last word and moves to IDLE; the counter does not wrap. busy = 1 throughout.
- **IDLE:** busy = 0. If clr_req = 1, the next state is CLEAR with clr_cnt = 0. User accesses presented in the same cycle as clr_req are still performed.
- **While busy:** we and re are ignored. Writes are dropped, there is no dout_valid, and dout holds. clr_req during CLEAR is ignored and does not restart the fill.
- **Byte writes:** a write updates only the bytes with wbe[i] = 1. If we = 1 and wbe = 0, the write is a no-op.
- **Read/write collision** (we & re & waddr == raddr, same cycle):
  - RDW_MODE = 0: dout returns the pre-write word.
  - RDW_MODE = 1: dout returns the merged word (enabled bytes from din, the rest from the array).
- Reads and writes to different addresses in the same cycle are fully independent.
- The memory array itself is not reset. It is defined only by the post-reset clear.

## Timing
- **Reset values:** dout = 0, dout_valid = 0, busy = 1, state = CLEAR, clr_cnt = 0.
- **After rst deasserts:** busy stays high for exactly DEPTH cycles, then falls.
- **Read latency:** a read accepted at edge N drives dout and dout_valid = 1 after edge N+READ_LATENCY.
- **Throughput:** one read per cycle. Back-to-back reads give consecutive valid pulses, in order.
- **READ_LATENCY = 2:** adds one output register stage. dout_valid is pipelined alongside the data.
- **Write latency:** a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- **Reset mid-operation:**
  - All outputs go to their reset values immediately.
  - In-flight reads in the pipeline are discarded.
  - The clear restarts from address 0.

## Structure
- Package `ram_pkg` holds:
  - the state typedef (ST_CLEAR, ST_IDLE);
  - the constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1;
  - the legal-value check for READ_LATENCY.
- Sub-module `ram_clear_ctrl` contains the FSM, clr_cnt and busy. It outputs the clear write port (clr_we, clr_addr), which the top muxes ahead of the user write port.
- The top holds the array, the byte-merge logic, the collision bypass and the read pipeline.

## Test plan
Benches use DATA_WIDTH = 16 and ADDR_WIDTH = 4 unless stated otherwise.

1. **Post-reset clear:** release rst.
   - Required: busy high for exactly 16 cycles, then low.
   - Then read addr 1 at edge N: dout = 0x0000 and dout_valid = 1 after edge N+1.
2. **Byte enables:** write 0xAABB to addr 2 with wbe = 2'b11, then write 0x11CC with wbe = 2'b01.
   - Required: a read of addr 2 returns 0xAACC.
3. **Collision:** addr 4 holds 0x1234; in one cycle write 0x5678 (wbe = 2'b11) and read addr 4.
   - RDW_MODE = 0: dout = 0x1234.
   - RDW_MODE = 1: dout = 0x5678.
   - Both modes: a later read returns 0x5678.
4. **Pipelined reads:** with READ_LATENCY = 2, read addr 2 then addr 4 on consecutive cycles.
   - Required: valid pulses at N+2 and N+3 carrying 0xAACC then 0x5678.
   - Required: no valid pulse in the gap cycles.
5. **Requested clear:** after the writes above, pulse clr_req, and assert we to addr 3 with data 0xFFFF during busy.
   - Required: busy high for 16 cycles.
   - Required: the write is dropped, a read during busy gives no dout_valid, and all 16 addresses then read 0x0000.
6. **Reset mid-clear:** assert rst at clear cycle 5 while a read is in flight.
   - Required: dout = 0, dout_valid = 0 and busy = 1 immediately.
   - Required: no stale valid pulse after release.
   - Required: a full 16-cycle busy after release.
